// File: rtl/wfsm_param_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Types and helpers shared by the dual-clock FIFO write- and read-side
// controllers.
//   wstate_e  : 2-bit controller state (RESET/IDLE/WRITE/FULL)
//   bin2gray  : binary -> reflected Gray (operands up to 32 bits, zero-extended)
//   gray2bin  : Gray -> binary (operands up to 32 bits, zero-extended)
// Callers size-cast the 32-bit results back to their own pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } wstate_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wfsm_param_if.sv
// -----------------------------------------------------------------------------
// wfsm_param_if
// Bundle between the FIFO write-side controller and its user / RAM / read-side
// synchroniser.
//   insert, flush, sync_rdptr        : driven by the master (producer side)
//   wren, wraddr, wrptr, full,
//   almost_full, level, overflow,
//   state                             : driven by the slave (wfsm_param)
//   ovf_count                         : only when WFSM_OVF_CNT_EN is defined
// Modports: master (producer / testbench), slave (controller).
// -----------------------------------------------------------------------------
interface wfsm_param_if #(
  parameter int ADDR_BITS = 8
`ifdef WFSM_OVF_CNT_EN
  , parameter int OVF_CNT_BITS = 8
`endif
);
  logic                 insert;
  logic                 flush;
  logic [ADDR_BITS:0]   sync_rdptr;
  logic                 wren;
  logic [ADDR_BITS-1:0] wraddr;
  logic [ADDR_BITS:0]   wrptr;
  logic                 full;
  logic                 almost_full;
  logic [ADDR_BITS:0]   level;
  logic                 overflow;
  logic [1:0]           state;
`ifdef WFSM_OVF_CNT_EN
  logic [OVF_CNT_BITS-1:0] ovf_count;

  modport master (
    output insert, flush, sync_rdptr,
    input  wren, wraddr, wrptr, full, almost_full, level, overflow, state, ovf_count
  );
  modport slave (
    input  insert, flush, sync_rdptr,
    output wren, wraddr, wrptr, full, almost_full, level, overflow, state, ovf_count
  );
`else
  modport master (
    output insert, flush, sync_rdptr,
    input  wren, wraddr, wrptr, full, almost_full, level, overflow, state
  );
  modport slave (
    input  insert, flush, sync_rdptr,
    output wren, wraddr, wrptr, full, almost_full, level, overflow, state
  );
`endif
endinterface

// File: rtl/gray2bin_conv.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
// Purely combinational Gray -> binary converter of parametrised width.
//   gray_i : W-bit Gray code
//   bin_o  : W-bit binary equivalent
// Each binary bit is the XOR of all Gray bits at or above it, written as an
// independent reduction per bit so no bit depends on another output bit.
// -----------------------------------------------------------------------------
module gray2bin_conv #(
  parameter int W = 9
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign bin_o[gi] = ^gray_i[W-1:gi];
  end

endmodule

// File: rtl/wfsm_param.sv
// -----------------------------------------------------------------------------
// wfsm_param
// Write-side controller of the dual-clock FIFO. Owns the binary write pointer,
// the registered Gray write pointer handed to the read-domain synchroniser and
// the RAM write strobe/address. Also reports full, fill level, almost-full and
// a sticky overflow flag. sync_rdptr must already be synchronised into clk_in.
//   clk_in : write-domain clock (rising edge)
//   rst    : synchronous active-high reset
//   bus    : wfsm_param_if.slave (insert/flush/sync_rdptr in; wren, wraddr,
//            wrptr, full, almost_full, level, overflow, state out)
// Optional: define WFSM_OVF_CNT_EN to add bus.ovf_count, a saturating count of
// inserts dropped while full (cleared by rst or flush).
// -----------------------------------------------------------------------------
module wfsm_param
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int AF_THRESH    = 2**ADDR_BITS - 4,
  parameter int OVF_CNT_BITS = 8
) (
  input  logic           clk_in,
  input  logic           rst,
  wfsm_param_if.slave    bus
);

  localparam int            A      = ADDR_BITS;
  localparam logic [A:0]    AF_LVL = (A+1)'(AF_THRESH);

  wstate_e    state_q, state_d;
  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wrptr_q, gray_next;
  logic [A:0] level_q, level_d;
  logic [A:0] rbin, full_cmp;
  logic       full_q, full_d;
  logic       af_q, ovf_q;
  logic       in_service, accept, reject;

  gray2bin_conv #(.W(A+1)) u_rd_g2b (
    .gray_i (bus.sync_rdptr),
    .bin_o  (rbin)
  );

  // Datapath next-state. Inserts are only serviced outside RESET and when no
  // flush/reset is pending; the full check uses the registered flag, so a
  // read-pointer advance only frees space from the following cycle.
  always_comb begin
    in_service = (state_q != ST_RESET) & ~bus.flush & ~rst;
    accept     = bus.insert & ~full_q & in_service;
    reject     = bus.insert &  full_q & in_service;
    wbin_d     = wbin_q + (A+1)'(accept);
    gray_next  = (A+1)'(bin2gray(32'(wbin_d)));
    // Full when write is exactly one lap ahead: in Gray that means the top two
    // bits are inverted relative to the read pointer and the rest match.
    full_cmp   = {~bus.sync_rdptr[A:A-1], bus.sync_rdptr[A-2:0]};
    full_d     = (gray_next == full_cmp);
    level_d    = wbin_d - rbin;
  end

  always_ff @(posedge clk_in) begin
    if (rst | bus.flush) begin
      wbin_q  <= '0;
      wrptr_q <= '0;
      full_q  <= 1'b0;
      level_q <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wrptr_q <= gray_next;
      full_q  <= full_d;
      level_q <= level_d;
      af_q    <= (level_d >= AF_LVL);
      if (reject) ovf_q <= 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_RESET;
    end else if (state_q == ST_RESET) begin
      state_d = ST_IDLE;
    end else if (full_d) begin
      state_d = ST_FULL;
    end else if (accept) begin
      state_d = ST_WRITE;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // FSM / datapath outputs
  always_comb begin
    bus.wren        = accept;
    bus.wraddr      = wbin_q[A-1:0];
    bus.wrptr       = wrptr_q;
    bus.full        = full_q;
    bus.almost_full = af_q;
    bus.level       = level_q;
    bus.overflow    = ovf_q;
    bus.state       = state_q;
  end

`ifdef WFSM_OVF_CNT_EN
  logic [OVF_CNT_BITS-1:0] ovf_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst | bus.flush) begin
      ovf_cnt_q <= '0;
    end else if (reject && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign bus.ovf_count = ovf_cnt_q;
`else
  // Counter width only matters when the counter exists; this empty block
  // keeps the parameter referenced in the default build.
  if (OVF_CNT_BITS < 1) begin : g_no_ovf_cnt
  end
`endif

endmodule

// File: tb/tb_wfsm_param.sv
module tb_wfsm_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wfsm_param_if #(
    .ADDR_BITS(4)
`ifdef WFSM_OVF_CNT_EN
    , .OVF_CNT_BITS(8)
`endif
  ) bus ();

  wfsm_param #(.ADDR_BITS(4), .AF_THRESH(12), .OVF_CNT_BITS(8)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: write count and read position as plain integers mod 32.
  int m_w = 0, m_r = 0, m_level = 0, m_st = 0, m_cnt = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;
  bit exp_wren, obs_wren;
  logic [3:0] exp_wraddr, obs_wraddr;

  function automatic logic [4:0] g5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic step(input bit ins, input bit fl, input bit rs);
    bit rej;
    int lvl;
    @(negedge clk);
    bus.insert = ins;
    bus.flush = fl;
    rst = rs;
    bus.sync_rdptr = g5(m_r);
    exp_wren = ins && !m_full && !fl && !rs && (m_st != 0);
    rej = ins && m_full && !fl && !rs && (m_st != 0);
    exp_wraddr = 4'(m_w);
    #1;
    obs_wren = bus.wren;
    obs_wraddr = bus.wraddr;
    @(posedge clk);
    if (rs || fl) begin
      m_w = 0; m_full = 0; m_level = 0; m_af = 0; m_ovf = 0; m_st = 0; m_cnt = 0;
    end else begin
      m_w = (m_w + (exp_wren ? 1 : 0)) % 32;
      lvl = ((m_w - m_r) % 32 + 32) % 32;
      m_level = lvl;
      m_full = (lvl == 16);
      m_af = (lvl >= 12);
      if (rej) begin
        m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (m_st == 0) m_st = 1;
      else if (m_full) m_st = 3;
      else if (exp_wren) m_st = 2;
      else m_st = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    m_r = 0;
    step(1, 0, 1);
    checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL reset_wren: got %0b expected 0", obs_wren); end
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if (bus.wrptr !== 5'd0) begin failures++; $display("FAIL reset_wrptr: got %0h expected 0", bus.wrptr); end
    checks++; if (bus.level !== 5'd0 || bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.overflow !== 1'b0)
      begin failures++; $display("FAIL reset_flags: got lvl=%0d full=%0b af=%0b ovf=%0b expected all 0",
                                  bus.level, bus.full, bus.almost_full, bus.overflow); end
    step(1, 0, 0);
    checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL reset_state_insert: got wren=%0b expected 0", obs_wren); end
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL reset_to_idle: got %0d expected 1", bus.state); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0);
      checks++; if (obs_wren !== 1'b1 || obs_wraddr !== 4'(i))
        begin failures++; $display("FAIL fill_write: got wren=%0b addr=%0d expected wren=1 addr=%0d", obs_wren, obs_wraddr, i); end
      checks++; if (bus.almost_full !== (i + 1 >= 12))
        begin failures++; $display("FAIL fill_af: got %0b expected %0b after write %0d", bus.almost_full, (i + 1 >= 12), i + 1); end
    end
    checks++; if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.state !== 2'd3)
      begin failures++; $display("FAIL fill_full: got full=%0b lvl=%0d st=%0d expected 1/16/3", bus.full, bus.level, bus.state); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL ovf_wren: got %0b expected 0", obs_wren); end
    end
    checks++; if (bus.wrptr !== 5'b11000) begin failures++; $display("FAIL ovf_wrptr: got %b expected 11000", bus.wrptr); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b expected 1", bus.overflow); end
`ifdef WFSM_OVF_CNT_EN
    checks++; if (bus.ovf_count !== 8'd3) begin failures++; $display("FAIL ovf_count: got %0d expected 3", bus.ovf_count); end
`endif
  endtask

  task automatic test_wrap();
    m_r = 8;
    step(0, 0, 0);
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL wrap_release: got full=%0b expected 0", bus.full); end
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      checks++; if (obs_wren !== 1'b1 || obs_wraddr !== 4'(i))
        begin failures++; $display("FAIL wrap_write: got wren=%0b addr=%0d expected wren=1 addr=%0d", obs_wren, obs_wraddr, i); end
    end
    checks++; if (bus.wrptr !== 5'b10100 || bus.full !== 1'b1)
      begin failures++; $display("FAIL wrap_end: got wrptr=%b full=%0b expected 10100/1", bus.wrptr, bus.full); end
  endtask

  task automatic test_flush();
    m_r = 0;
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    checks++; if (bus.level !== 5'd10) begin failures++; $display("FAIL flush_prelevel: got %0d expected 10", bus.level); end
    step(1, 1, 0);
    checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL flush_wren: got %0b expected 0", obs_wren); end
    checks++; if (bus.state !== 2'd0 || bus.wrptr !== 5'd0 || bus.level !== 5'd0 || bus.overflow !== 1'b0)
      begin failures++; $display("FAIL flush_clear: got st=%0d wrptr=%0h lvl=%0d ovf=%0b expected 0/0/0/0",
                                  bus.state, bus.wrptr, bus.level, bus.overflow); end
    step(1, 0, 0);
    checks++; if (obs_wren !== 1'b0 || bus.level !== 5'd0 || bus.state !== 2'd1)
      begin failures++; $display("FAIL flush_reset_cycle: got wren=%0b lvl=%0d st=%0d expected 0/0/1", obs_wren, bus.level, bus.state); end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    checks++; if (bus.level !== 5'd5) begin failures++; $display("FAIL rmb_level: got %0d expected 5", bus.level); end
    step(1, 0, 1);
    checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL rmb_wren: got %0b expected 0", obs_wren); end
    checks++; if (bus.state !== 2'd0 || bus.wrptr !== 5'd0 || bus.level !== 5'd0 || bus.full !== 1'b0)
      begin failures++; $display("FAIL rmb_clear: got st=%0d wrptr=%0h lvl=%0d full=%0b expected 0", bus.state, bus.wrptr, bus.level, bus.full); end
    step(1, 0, 0);
    step(1, 0, 0);
    checks++; if (obs_wren !== 1'b1 || obs_wraddr !== 4'd0)
      begin failures++; $display("FAIL rmb_resume: got wren=%0b addr=%0d expected 1/0", obs_wren, obs_wraddr); end
  endtask

  task automatic test_full_release();
    m_r = 0;
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0);
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL rel_full: got %0b expected 1", bus.full); end
    m_r = 1;
    step(0, 0, 0);
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL rel_deassert: got %0b expected 0", bus.full); end
    step(1, 0, 0);
    checks++; if (obs_wren !== 1'b1 || obs_wraddr !== 4'd0)
      begin failures++; $display("FAIL rel_accept: got wren=%0b addr=%0d expected 1/0", obs_wren, obs_wraddr); end
    // Insert while read advances and full is still set: rejected, overflow sets.
    m_r = 2;
    step(1, 0, 0);
    checks++; if (obs_wren !== 1'b0 || bus.overflow !== 1'b1)
      begin failures++; $display("FAIL rel_race: got wren=%0b ovf=%0b expected 0/1", obs_wren, bus.overflow); end
  endtask

  task automatic test_random();
    bit ins, fl;
    m_r = 0;
    step(0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      ins = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 2);
      if (fl) m_r = 0;
      else if (m_level > 0 && $urandom_range(0, 99) < 40) m_r = (m_r + 1) % 32;
      step(ins, fl, 0);
      checks++; if (obs_wren !== exp_wren || (exp_wren && obs_wraddr !== exp_wraddr))
        begin failures++; $display("FAIL rnd_write[%0d]: got wren=%0b addr=%0d expected wren=%0b addr=%0d",
                                    n, obs_wren, obs_wraddr, exp_wren, exp_wraddr); end
      checks++; if (bus.level !== 5'(m_level) || bus.full !== m_full || bus.almost_full !== m_af ||
                    bus.overflow !== m_ovf || bus.state !== 2'(m_st) || bus.wrptr !== g5(m_w))
        begin failures++; $display("FAIL rnd_regs[%0d]: got lvl=%0d full=%0b af=%0b ovf=%0b st=%0d wrptr=%0h expected %0d/%0b/%0b/%0b/%0d/%0h",
                                    n, bus.level, bus.full, bus.almost_full, bus.overflow, bus.state, bus.wrptr,
                                    m_level, m_full, m_af, m_ovf, m_st, g5(m_w)); end
`ifdef WFSM_OVF_CNT_EN
      checks++; if (bus.ovf_count !== 8'(m_cnt))
        begin failures++; $display("FAIL rnd_ovf_count[%0d]: got %0d expected %0d", n, bus.ovf_count, m_cnt); end
`endif
    end
  endtask

  initial begin
    bus.insert = 1'b0;
    bus.flush = 1'b0;
    bus.sync_rdptr = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_flush();
    test_reset_mid_burst();
    test_full_release();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
